// File: rtl/instr_loader.sv
// instr_loader: packs decoded MIPS fields into 32-bit words and writes them sequentially to imem
module instr_loader #(
    parameter int n = 32,
    parameter int AW = 32,
    parameter int DEPTH = 64,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [5:0]    op,
    input  logic [5:0]    funct,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [n-1:0]  wdata,
    output logic [6:0]    count,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [6:0] DEPTH7 = 7'(DEPTH);
    state_t state_q, state_d;
    logic we_q, we_d, full_q, full_d, err_q, err_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic [6:0] count_q, count_d;
    logic [31:0] enc;
    logic ok, accept;
    assign in_ready = (state_q == LOAD) && (count_q < DEPTH7);
    assign accept = in_valid && in_ready;
    assign we = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;
    assign busy = state_q == LOAD;
    assign done = state_q == DONE;
    assign full = full_q;
    assign err = err_q;
    // Format follows from the opcode: R-type, J-type, otherwise I-type
    always_comb begin
        enc = (op == 6'h00) ? {6'h00, rs, rt, rd, shamt, funct} :
              (op == 6'h02 || op == 6'h03) ? {op, target} : {op, rs, rt, imm};
        ok = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03};
    end
    // Next state: session control, write pulse, post-write address advance
    always_comb begin
        state_d = state_q;
        we_d = 1'b0;
        wdata_d = wdata_q;
        waddr_d = we_q ? waddr_q + AW'(4) : waddr_q;
        count_d = count_q;
        full_d = full_q;
        err_d = err_q;
        if (state_q != LOAD && start) begin
            state_d = LOAD;
            waddr_d = BASE_ADDR;
            count_d = '0;
            full_d = 1'b0;
            err_d = 1'b0;
        end else if (accept) begin
            if (ok) begin
                we_d = 1'b1;
                wdata_d = n'(enc);
                count_d = count_q + 7'd1;
            end else begin
                err_d = 1'b1;
            end
            if (ok && count_q + 7'd1 == DEPTH7) begin
                full_d = 1'b1;
                state_d = DONE;
            end else if (in_last) begin
                state_d = DONE;
            end
        end
    end
    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q <= 1'b0;
            wdata_q <= '0;
            waddr_q <= BASE_ADDR;
            count_q <= '0;
            full_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            full_q <= full_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed checks of encoding, addressing, error, depth and reset behaviour
module tb_instr_loader;
    logic clk = 1'b0, reset, start, in_valid, in_last;
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic in_ready, we, busy, done, full, err;
    logic [31:0] waddr, wdata;
    logic [6:0] count;
    logic r4, we4, busy4, done4, full4, err4;
    logic [31:0] waddr4, wdata4;
    logic [6:0] count4;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    instr_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .we(we), .waddr(waddr), .wdata(wdata), .count(count),
        .busy(busy), .done(done), .full(full), .err(err)
    );

    instr_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(r4),
        .in_last(in_last), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .we(we4), .waddr(waddr4), .wdata(wdata4), .count(count4),
        .busy(busy4), .done(done4), .full(full4), .err(err4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                        input logic [25:0] tg, input logic last);
        in_valid = 1'b1;
        op = o; rs = s; rt = t; rd = d; shamt = 5'd0; funct = f; imm = i; target = tg;
        in_last = last;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op = '0; funct = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", in_ready, 0); chk("rst_we", we, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_waddr", waddr, 0); chk("rst_wdata", wdata, 0);
        chk("rst_count", count, 0); chk("rst_full", full, 0); chk("rst_err", err, 0);
        in_valid = 1'b1;
        tick();
        chk("idle_ignores_valid_we", we, 0);
        chk("idle_ignores_valid_count", count, 0);
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", busy, 1); chk("load_ready", in_ready, 1);
        beat(6'h00, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0, 1'b0);
        tick();
        chk("add_we", we, 1); chk("add_wdata", wdata, 32'h01095020);
        chk("add_waddr", waddr, 32'h0); chk("add_count", count, 1);
        beat(6'h23, 5'd16, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
        tick();
        chk("lw_we", we, 1); chk("lw_wdata", wdata, 32'h8E080004); chk("lw_waddr", waddr, 32'h4);
        beat(6'h04, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
        tick();
        chk("beq_we", we, 1); chk("beq_wdata", wdata, 32'h1022FFFF); chk("beq_waddr", waddr, 32'h8);
        chk("beq_count", count, 3);
        beat(6'h3F, 5'd3, 5'd4, 5'd5, 6'h0, 16'h1234, 26'h0, 1'b0);
        tick();
        chk("bad_we", we, 0); chk("bad_err", err, 1); chk("bad_count", count, 3);
        chk("bad_waddr", waddr, 32'hC);
        beat(6'h08, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0);
        tick();
        chk("addi_we", we, 1); chk("addi_wdata", wdata, 32'h20220005);
        chk("addi_waddr_unchanged", waddr, 32'hC); chk("addi_count", count, 4);
        chk("d4_full", full4, 1); chk("d4_ready_drop", r4, 0); chk("d4_done", done4, 1);
        chk("d4_waddr", waddr4, 32'hC);
        beat(6'h02, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
        tick();
        chk("j_we", we, 1); chk("j_wdata", wdata, 32'h08000010); chk("j_waddr", waddr, 32'h10);
        chk("j_done", done, 1); chk("j_busy", busy, 0); chk("j_ready", in_ready, 0);
        chk("j_err_sticky", err, 1); chk("j_full", full, 0);
        chk("d4_no_accept_we", we4, 0); chk("d4_count", count4, 4);
        beat(6'h00, 5'd1, 5'd1, 5'd1, 6'h20, 16'h0, 26'h0, 1'b0);
        tick();
        chk("done_ignores_we", we, 0); chk("done_count", count, 5); chk("done_waddr", waddr, 32'h14);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_count", count, 0); chk("restart_err", err, 0); chk("restart_waddr", waddr, 0);
        chk("restart_d4_full", full4, 0); chk("restart_d4_busy", busy4, 1);
        for (int i = 0; i < 5; i++) begin
            beat(6'h00, 5'd1, 5'd2, 5'(i), 6'h20, 16'h0, 26'h0, 1'b0);
            tick();
            if (i < 4) begin
                chk($sformatf("d4_we%0d", i), we4, 1);
                chk($sformatf("d4_waddr%0d", i), waddr4, 32'(i * 4));
                chk($sformatf("d4_wdata%0d", i), wdata4, 32'h00220020 | (32'(i) << 11));
            end else begin
                chk("d4_5th_we", we4, 0); chk("d4_5th_count", count4, 4);
                chk("d64_5th_we", we, 1); chk("d64_5th_waddr", waddr, 32'h10);
            end
        end
        chk("d4_full_end", full4, 1); chk("d4_ready_end", r4, 0); chk("d64_ready", in_ready, 1);
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignored_start_count", count, 5);
        beat(6'h00, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0, 1'b0);
        tick(); tick();
        chk("pre_rst_count", count, 7); chk("pre_rst_waddr", waddr, 32'h18);
        reset = 1'b1;
        tick();
        chk("rst6_busy", busy, 0); chk("rst6_waddr", waddr, 0); chk("rst6_count", count, 0);
        chk("rst6_we", we, 0); chk("rst6_ready", in_ready, 0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
